// File: rtl/store_buffer_if.sv
// store_buffer_if: CPU-side request bundle plus dataMemory port of the store buffer.
// master = MEM stage / memory side, slave = store_buffer.
interface store_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] cpuAddr;
    logic [DATA_W-1:0] cpuWrData;
    logic              cpuMemWrite;
    logic              cpuMemRead;
    logic [DATA_W-1:0] cpuReadData;
    logic              stall;
    logic              sbEmpty;
    logic [ADDR_W-1:0] memAddress;
    logic [DATA_W-1:0] memWrData;
    logic              memMemWrite;
    logic              memMemRead;
    logic [DATA_W-1:0] memReadData;

    modport master (
        output cpuAddr, cpuWrData, cpuMemWrite, cpuMemRead, memReadData,
        input  cpuReadData, stall, sbEmpty,
        input  memAddress, memWrData, memMemWrite, memMemRead
    );

    modport slave (
        input  cpuAddr, cpuWrData, cpuMemWrite, cpuMemRead, memReadData,
        output cpuReadData, stall, sbEmpty,
        output memAddress, memWrData, memMemWrite, memMemRead
    );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between MEM stage and dataMemory, with load forwarding.
// Define STORE_COALESCE_EN to merge stores to an already-buffered address in place.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic           clk,
    input logic           resetN,
    store_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PW-1:0]     head_q;
    logic [PW-1:0]     tail_q;
    logic [CW-1:0]     count_q;

    logic              wr;
    logic              rd;
    logic              full;
    logic              empty;
    logic              hit;
    logic [PW-1:0]     idx;
    logic [PW-1:0]     hit_idx;
    logic [DATA_W-1:0] fdata;
    logic              coal;
    logic              enq;
    logic              drain;

    assign wr    = bus.cpuMemWrite;
    assign rd    = bus.cpuMemRead & ~bus.cpuMemWrite;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Oldest-to-youngest scan: the last match wins, giving the youngest entry.
    always_comb begin
        hit     = 1'b0;
        hit_idx = head_q;
        fdata   = '0;
        idx     = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (valid_q[idx] && addr_q[idx] == bus.cpuAddr) begin
                hit     = 1'b1;
                hit_idx = idx;
                fdata   = data_q[idx];
            end
        end
    end

`ifdef STORE_COALESCE_EN
    assign coal = wr & hit;
`else
    assign coal = 1'b0;
`endif

    assign enq   = wr & ~coal & ~full;
    assign drain = (wr & ~coal & full) | (~wr & ~rd & ~empty);

    assign bus.stall       = wr & ~coal & full;
    assign bus.sbEmpty     = empty;
    assign bus.memMemWrite = drain;
    assign bus.memMemRead  = rd;
    assign bus.memWrData   = drain ? data_q[head_q] : '0;

    always_comb begin
        bus.memAddress = '0;
        if (drain)
            bus.memAddress = addr_q[head_q];
        else if (rd)
            bus.memAddress = bus.cpuAddr;
    end

    assign bus.cpuReadData = !rd ? '0 : (hit ? fdata : bus.memReadData);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (enq) begin
                addr_q[tail_q]  <= bus.cpuAddr;
                data_q[tail_q]  <= bus.cpuWrData;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            if (drain) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (coal)
                data_q[hit_idx] <= bus.cpuWrData;
            if (enq)
                count_q <= count_q + 1'b1;
            else if (drain)
                count_q <= count_q - 1'b1;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: scoreboard bench for store_buffer; queued stores are
// pushed on acceptance and popped when the DUT drains them to dataMemory.
module tb_store_buffer;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    ent_t sb[$];

    store_buffer_if #(.ADDR_W(32), .DATA_W(32)) bus();

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk),
        .resetN(resetN),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] mrd);
        bus.cpuMemWrite = w;
        bus.cpuMemRead  = r;
        bus.cpuAddr     = a;
        bus.cpuWrData   = d;
        bus.memReadData = mrd;
    endtask

    // One cycle: drive after negedge, check combinational outputs, model commits.
    task automatic step(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] mrd);
        logic        e_stall, e_mw, e_mr;
        logic [31:0] e_addr, e_wd, e_rdata;
        int          m;
        ent_t        hd;
        @(negedge clk);
        drive(w, r, a, d, mrd);
        #1;
        e_stall = 0; e_mw = 0; e_mr = 0;
        e_addr = 0; e_wd = 0; e_rdata = 0;
        check("sbEmpty", 64'(bus.sbEmpty), 64'(sb.size() == 0));
        m = -1;
        foreach (sb[j]) if (sb[j].addr == a) m = j;
        if (w) begin
`ifdef STORE_COALESCE_EN
            if (m >= 0) sb[m].data = d;
            else
`endif
            if (sb.size() < DEPTH) begin
                sb.push_back('{addr: a, data: d});
            end else begin
                e_stall = 1; e_mw = 1;
                hd = sb.pop_front();
                e_addr = hd.addr; e_wd = hd.data;
            end
        end else if (r) begin
            e_mr = 1; e_addr = a;
            e_rdata = (m >= 0) ? sb[m].data : mrd;
        end else if (sb.size() > 0) begin
            e_mw = 1;
            hd = sb.pop_front();
            e_addr = hd.addr; e_wd = hd.data;
        end
        check("stall", 64'(bus.stall), 64'(e_stall));
        check("memMemWrite", 64'(bus.memMemWrite), 64'(e_mw));
        check("memMemRead", 64'(bus.memMemRead), 64'(e_mr));
        check("memAddress", 64'(bus.memAddress), 64'(e_addr));
        check("memWrData", 64'(bus.memWrData), 64'(e_wd));
        check("cpuReadData", 64'(bus.cpuReadData), 64'(e_rdata));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0BAD_0BAD);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("rst_sbEmpty", 64'(bus.sbEmpty), 64'd1);
        check("rst_stall", 64'(bus.stall), 64'd0);
        check("rst_memMemWrite", 64'(bus.memMemWrite), 64'd0);
        check("rst_memAddress", 64'(bus.memAddress), 64'd0);
        check("rst_cpuReadData", 64'(bus.cpuReadData), 64'd0);
        resetN = 1'b1;
        idle(1);

        // Single store then drain.
        step(1, 0, 32'h10, 32'hAAAA_0001, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        #1;
        check("t1_mw", 64'(bus.memMemWrite), 64'd1);
        check("t1_addr", 64'(bus.memAddress), 64'h10);
        check("t1_data", 64'(bus.memWrData), 64'hAAAA_0001);
        void'(sb.pop_front());
        idle(1);

        // Forwarding hit while entry stays queued.
        step(1, 0, 32'h20, 32'h5, 0);
        step(0, 1, 32'h20, 0, 32'hDEAD_BEEF);
        check("t2_fwd", 64'(bus.cpuReadData), 64'h5);
        check("t2_sbEmpty", 64'(bus.sbEmpty), 64'd0);
        idle(2);

        // Full queue: 5th store stalls with forced drain, then is accepted.
        for (int i = 0; i < 5; i++) step(1, 0, 32'(i), 32'(i + 100), 0);
        step(1, 0, 32'h4, 32'd104, 0);
        check("t3_accept", 64'(bus.stall), 64'd0);
        step(1, 0, 32'h5, 32'd105, 0);
        check("t3_full_again", 64'(bus.stall), 64'd1);
        step(1, 0, 32'h5, 32'd105, 0);
        idle(5);

        // Same-address stores: forwarding returns youngest.
        step(1, 0, 32'h30, 32'h1, 0);
        step(1, 0, 32'h30, 32'h2, 0);
        step(0, 1, 32'h30, 0, 32'h77);
        check("t4_fwd", 64'(bus.cpuReadData), 64'h2);
        step(0, 0, 0, 0, 0);
`ifdef STORE_COALESCE_EN
        check("t4_drain", 64'(bus.memWrData), 64'h2);
`else
        check("t4_drain", 64'(bus.memWrData), 64'h1);
`endif
        idle(2);

        // Asynchronous reset with entries queued.
        for (int i = 0; i < 3; i++) step(1, 0, 32'(i + 8), 32'(i), 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        #2 resetN = 1'b0;
        #1;
        check("t5_sbEmpty", 64'(bus.sbEmpty), 64'd1);
        check("t5_mw", 64'(bus.memMemWrite), 64'd0);
        sb.delete();
        @(negedge clk);
        resetN = 1'b1;
        idle(3);

        // Load miss and read-data gating.
        step(0, 1, 32'h40, 0, 32'h1234);
        check("t6_miss", 64'(bus.cpuReadData), 64'h1234);
        step(0, 0, 32'h40, 0, 32'h1234);
        check("t6_gate", 64'(bus.cpuReadData), 64'h0);

        // Read and write together behave as a store.
        step(1, 1, 32'h50, 32'h9, 32'h55);
        idle(2);

        // Random mix over a small address range to exercise hits and wrap.
        for (int i = 0; i < 400; i++) begin
            int op;
            op = $urandom_range(0, 9);
            step(op < 5, op >= 5 && op < 8, 32'($urandom_range(0, 5)),
                 $urandom, $urandom);
        end
        idle(6);
        check("final_empty", 64'(bus.sbEmpty), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
